ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
PS/2 keyboard front end that feeds the memory-mapped I/O block. It synchronises the raw PS2_CLK/PS2_DAT pins, deframes 11-bit device-to-host frames and strips E0/F0 prefixes into make/break events. It also keeps a debounced "jump" key state for the game loop. The CPU consumes it through a sticky data-ready flag and an acknowledge strobe, exposed as I/O registers.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on both PS/2 lines (min 2).
TIMEOUT_CYCLES, 50000, clk cycles with no PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
JUMP_CODE, 8'h29, non-extended scan code tracked as the jump key (space).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
PS2_CLK  in  1  raw keyboard clock pin, asynchronous.
PS2_DAT  in  1  raw keyboard data pin, asynchronous.
ack  in  1  CPU read-acknowledge; clears data_ready.
scan_code  out  8  last decoded scan code, prefixes removed.
is_break  out  1  scan_code was preceded by F0.
is_ext  out  1  scan_code was preceded by E0.
scan_valid  out  1  one-cycle pulse when scan_code/is_break/is_ext update.
data_ready  out  1  sticky: set by scan_valid, cleared by ack.
key_down  out  1  level: jump key currently held.
jump_pulse  out  1  one-cycle pulse on the jump key's press edge, not on autorepeat.
frame_err  out  1  one-cycle pulse on bad stop bit or timeout.
parity_err  out  1  one-cycle pulse on odd-parity failure.

Behaviour:
- Reset (async, active-high): synchroniser flops to 1, FSM to IDLE, bit count 0, timeout 0, prefix flags 0. All outputs 0.
- Sync/edge: the falling edge is true in the cycle where the synced clock was 1 last cycle and is 0 now. The data line is sampled from the synced data in that same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on a falling edge, except timeout.
  - IDLE: data=0 → DATA, count=0. data=1 → stay (glitch, no error).
  - DATA: shift the bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: checks are made in this order:
    - data=0 → frame_err.
    - otherwise, XOR(8 data bits, parity) != 1 → parity_err.
    - otherwise the byte is good.
    - Always return to IDLE.
- Timeout: the counter resets on every falling edge and stays 0 in IDLE. When it reaches TIMEOUT_CYCLES-1 outside IDLE:
  - FSM → IDLE, frame_err pulse, prefix flags cleared.
  - A falling edge in that same cycle is ignored.
- Decoder (good byte):
  - E0 → set ext flag. F0 → set brk flag. No output either way.
  - Any other byte: the next cycle sets scan_code/is_ext/is_break from the byte and flags, pulses scan_valid, and clears both flags.
  - Latency: STOP edge in cycle N → scan_valid in cycle N+1.
- Error handling: on any error, prefix flags are cleared and scan_code is unchanged.
- Jump key (non-extended JUMP_CODE only; is_ext=1 is ignored):
  - Make with key_down=0 → key_down=1 and jump_pulse, both in the same cycle as scan_valid.
  - Make with key_down=1 (autorepeat) → no pulse.
  - Break → key_down=0.
- data_ready: scan_valid sets it, ack clears it. If ack and scan_valid arrive in the same cycle, set wins. ack while data_ready=0 has no effect.
- Error pulses never coincide with scan_valid for the same frame.
- Reset asserted mid-frame: the partial frame is discarded. The first frame is accepted only after a fresh start bit.

Decomposition:
- Package ps2_pkg holds:
  - the frame state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_FRAME_BITS=11.
- Sub-module ps2_frame_rx covers synchronisers, edge detect, frame FSM, parity and timeout. It outputs byte, byte_valid, frame_err and parity_err.
- The top level holds the prefix decoder, jump-key tracker and data_ready.

Test Plan:
- Frame 0x1C (parity 0, stop 1) at 12.5 kHz PS/2 clock → scan_valid one cycle after the 11th edge; scan_code=1C, is_break=0, is_ext=0, data_ready=1.
- Sequence 29, 29, F0 29 → key_down rises with one jump_pulse on the first 29 only. The second 29 gives scan_valid but no pulse. F0 29 gives is_break=1 and key_down=0.
- E0 75 then E0 F0 75 → two scan_valid, both with code 75 and is_ext=1; the first has is_break=0, the second is_break=1. key_down stays 0.
- 0x1C sent with parity bit 1 → parity_err pulse, no scan_valid, scan_code keeps its previous value.
- Frame cut off after 5 data bits, idle >TIMEOUT_CYCLES, then a clean 0x1C → frame_err pulse at timeout, then a correct 1C decode.
- ack asserted in the same cycle as scan_valid → data_ready=1. ack on the next cycle → data_ready=0.
- Reset mid-frame after 4 bits, then a full 0x29 → all outputs 0 during reset, then key_down=1 with jump_pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: frame states and protocol constants shared by the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises PS/2 pins and deframes 11-bit frames into checked bytes
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_parity_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  frame_state_e           r_state, w_next;
  logic [2:0]             r_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TW-1:0]          r_to;
  logic                   w_clk_s, w_dat, w_fall, w_timeout, w_edge, w_stop;
  assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
  assign w_dat     = r_dat_sync[SYNC_STAGES-1];
  assign w_fall    = r_clk_prev & ~w_clk_s;
  assign w_timeout = (r_state != IDLE) && (r_to == TW'(TIMEOUT_CYCLES - 1));
  // a falling edge that lands on the timeout cycle is dropped
  assign w_edge    = w_fall & ~w_timeout;
  assign o_byte    = r_shift;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_clk_prev <= w_clk_s;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = IDLE;
    else if (w_fall)
      case (r_state)
        IDLE:    w_next = w_dat ? IDLE : DATA;
        DATA:    w_next = (r_cnt == 3'(PS2_FRAME_BITS - 4)) ? PARITY : DATA;
        PARITY:  w_next = STOP;
        default: w_next = IDLE;
      endcase
  end
  always_comb begin
    w_stop       = w_edge && (r_state == STOP);
    o_frame_err  = w_timeout | (w_stop & ~w_dat);
    o_parity_err = w_stop & w_dat & ~(^{r_shift, r_par});
    o_byte_valid = w_stop & w_dat & (^{r_shift, r_par});
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_to    <= '0;
    end else begin
      r_to <= (r_state == IDLE || w_fall || w_timeout) ? '0 : r_to + TW'(1);
      if (w_edge && r_state == IDLE) r_cnt <= '0;
      if (w_edge && r_state == DATA) begin
        r_shift <= {w_dat, r_shift[7:1]};
        r_cnt   <= r_cnt + 3'd1;
      end
      if (w_edge && r_state == PARITY) r_par <= w_dat;
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard front end with prefix decoding, jump-key tracking and CPU handshake
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] JUMP_CODE      = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       ack,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_ext,
  output logic       scan_valid,
  output logic       data_ready,
  output logic       key_down,
  output logic       jump_pulse,
  output logic       frame_err,
  output logic       parity_err
);
  logic [7:0] w_byte;
  logic       w_valid, w_ferr, w_perr, w_emit, w_jump, w_err;
  logic       r_ext, r_brk;
  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_dat   (PS2_DAT),
    .o_byte      (w_byte),
    .o_byte_valid(w_valid),
    .o_frame_err (w_ferr),
    .o_parity_err(w_perr)
  );
  assign w_emit = w_valid && w_byte != PS2_PREFIX_EXT && w_byte != PS2_PREFIX_BRK;
  assign w_jump = w_emit && w_byte == JUMP_CODE && !r_ext;
  assign w_err  = w_ferr | w_perr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scan_code  <= '0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      scan_valid <= 1'b0;
      data_ready <= 1'b0;
      key_down   <= 1'b0;
      jump_pulse <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      scan_valid <= w_emit;
      frame_err  <= w_ferr;
      parity_err <= w_perr;
      jump_pulse <= w_jump & ~r_brk & ~key_down;
      // set wins over a simultaneous acknowledge
      data_ready <= scan_valid | (data_ready & ~ack);
      r_ext      <= (w_valid && w_byte == PS2_PREFIX_EXT) || (r_ext && !w_emit && !w_err);
      r_brk      <= (w_valid && w_byte == PS2_PREFIX_BRK) || (r_brk && !w_emit && !w_err);
      if (w_emit) begin
        scan_code <= w_byte;
        is_ext    <= r_ext;
        is_break  <= r_brk;
      end
      if (w_jump) key_down <= ~r_brk;
    end
endmodule
